// File: rtl/pingpong_buffer_ctrl.sv
// Ping-pong write controller for the dual-port audio RAM: fills the half not read by the CoDec
// and swaps halves on the filled/empty/ack handshake. Optional: PINGPONG_UNDERRUN_CNT_EN adds underrun_cnt_o.
module pingpong_buffer_ctrl #(
    parameter int BUFFER_ADDR_BITS = 8,
    parameter int DATA_WIDTH       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       src_data_i,
    input  logic                        src_valid_i,
    output logic                        src_ready_o,
    output logic                        ram_wren_o,
    output logic [BUFFER_ADDR_BITS:0]   ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0]       ram_wr_data_o,
    output logic                        buf_sel_o,
    output logic                        buf_filled_o,
    input  logic                        codec_empty_i,
`ifdef PINGPONG_UNDERRUN_CNT_EN
    output logic [15:0]                 underrun_cnt_o,
`endif
    output logic                        codec_empty_ack_o
);

    typedef enum logic {
        WRITE = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [BUFFER_ADDR_BITS-1:0] WPTR_LAST = '1;

    state_t                      state, state_nxt;
    logic [BUFFER_ADDR_BITS-1:0] wptr, wptr_nxt;
    logic                        buf_sel_nxt;
    logic                        buf_filled_nxt;
    logic                        ack_nxt;
    logic                        wren_nxt;
    logic [BUFFER_ADDR_BITS:0]   addr_nxt;
    logic [DATA_WIDTH-1:0]       data_nxt;

    assign src_ready_o = (state == WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= WRITE;
            wptr              <= '0;
            buf_sel_o         <= 1'b0;
            buf_filled_o      <= 1'b0;
            codec_empty_ack_o <= 1'b0;
            ram_wren_o        <= 1'b0;
            ram_wr_addr_o     <= '0;
            ram_wr_data_o     <= '0;
        end else begin
            state             <= state_nxt;
            wptr              <= wptr_nxt;
            buf_sel_o         <= buf_sel_nxt;
            buf_filled_o      <= buf_filled_nxt;
            codec_empty_ack_o <= ack_nxt;
            ram_wren_o        <= wren_nxt;
            ram_wr_addr_o     <= addr_nxt;
            ram_wr_data_o     <= data_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wptr_nxt       = wptr;
        buf_sel_nxt    = buf_sel_o;
        buf_filled_nxt = buf_filled_o;
        ack_nxt        = 1'b0;
        wren_nxt       = 1'b0;
        addr_nxt       = ram_wr_addr_o;
        data_nxt       = ram_wr_data_o;
        case (state)
            WRITE: begin
                // codec_empty_i is deliberately ignored here so a stale level cannot re-swap
                if (src_valid_i) begin
                    wren_nxt = 1'b1;
                    data_nxt = src_data_i;
                    addr_nxt = {~buf_sel_o, wptr};
                    wptr_nxt = wptr + 1'b1;
                    if (wptr == WPTR_LAST) begin
                        state_nxt      = FULL;
                        buf_filled_nxt = 1'b1;
                    end
                end
            end
            FULL: begin
                // wptr has already wrapped to 0, so only the half select changes
                if (codec_empty_i) begin
                    buf_sel_nxt    = ~buf_sel_o;
                    buf_filled_nxt = 1'b0;
                    ack_nxt        = 1'b1;
                    state_nxt      = WRITE;
                end
            end
            default: state_nxt = WRITE;
        endcase
    end

`ifdef PINGPONG_UNDERRUN_CNT_EN
    logic codec_empty_p1;

    // Reader went empty while we are still filling: count it, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            codec_empty_p1 <= 1'b0;
            underrun_cnt_o <= '0;
        end else begin
            codec_empty_p1 <= codec_empty_i;
            if ((state == WRITE) && codec_empty_i && !codec_empty_p1
                && (underrun_cnt_o != 16'hFFFF)) begin
                underrun_cnt_o <= underrun_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pingpong_buffer_ctrl.sv
// Directed testbench for pingpong_buffer_ctrl: fill, swap, underrun, backpressure and reset scenarios.
module tb_pingpong_buffer_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic          ram_wren;
    logic [AW:0]   ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          buf_sel;
    logic          buf_filled;
    logic          codec_empty;
    logic          codec_empty_ack;
`ifdef PINGPONG_UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt;
`endif

    int vec;
    int miss;

    pingpong_buffer_ctrl #(
        .BUFFER_ADDR_BITS(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src_data_i(src_data),
        .src_valid_i(src_valid),
        .src_ready_o(src_ready),
        .ram_wren_o(ram_wren),
        .ram_wr_addr_o(ram_wr_addr),
        .ram_wr_data_o(ram_wr_data),
        .buf_sel_o(buf_sel),
        .buf_filled_o(buf_filled),
        .codec_empty_i(codec_empty),
`ifdef PINGPONG_UNDERRUN_CNT_EN
        .underrun_cnt_o(underrun_cnt),
`endif
        .codec_empty_ack_o(codec_empty_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; src_valid = 1'b0; src_data = '0; codec_empty = 1'b0;
        step(); step();
        vec++;
        if ({ram_wren, ram_wr_addr, ram_wr_data, buf_sel, buf_filled, codec_empty_ack} !== '0) begin
            miss++;
            $display("FAIL reset_outputs: got wren=%b addr=%h data=%h sel=%b filled=%b ack=%b, want all 0",
                     ram_wren, ram_wr_addr, ram_wr_data, buf_sel, buf_filled, codec_empty_ack);
        end
`ifdef PINGPONG_UNDERRUN_CNT_EN
        vec++;
        if (underrun_cnt !== 16'd0) begin
            miss++;
            $display("FAIL reset_underrun: got %0d want 0", underrun_cnt);
        end
`endif
        rst = 1'b0;
        #1;
        vec++;
        if (src_ready !== 1'b1) begin
            miss++;
            $display("FAIL reset_ready: got %b want 1", src_ready);
        end
        step();
        vec++;
        if (ram_wren !== 1'b0 || buf_sel !== 1'b0 || src_ready !== 1'b1) begin
            miss++;
            $display("FAIL idle_after_reset: got wren=%b sel=%b ready=%b want 0 0 1", ram_wren, buf_sel, src_ready);
        end
    endtask

    task automatic test_fill_half1();
        logic [AW:0] exp_addr;
        for (int i = 0; i < 256; i++) begin
            src_valid = 1'b1;
            src_data  = DW'(i);
            exp_addr  = 9'h100 + 9'(i);
            step();
            vec++;
            if (ram_wren !== 1'b1 || ram_wr_addr !== exp_addr || ram_wr_data !== DW'(i)
                || buf_filled !== (i == 255) || src_ready !== (i != 255)) begin
                miss++;
                $display("FAIL fill1[%0d]: got wren=%b addr=%h data=%h filled=%b ready=%b want 1 %h %h %b %b",
                         i, ram_wren, ram_wr_addr, ram_wr_data, buf_filled, src_ready,
                         exp_addr, DW'(i), (i == 255), (i != 255));
            end
        end
        src_valid = 1'b0;
    endtask

    task automatic test_swap();
        step();
        vec++;
        if (buf_sel !== 1'b0 || buf_filled !== 1'b1 || codec_empty_ack !== 1'b0
            || ram_wren !== 1'b0 || src_ready !== 1'b0) begin
            miss++;
            $display("FAIL full_wait: got sel=%b filled=%b ack=%b wren=%b ready=%b want 0 1 0 0 0",
                     buf_sel, buf_filled, codec_empty_ack, ram_wren, src_ready);
        end
        codec_empty = 1'b1;
        step();
        vec++;
        if (buf_sel !== 1'b1 || codec_empty_ack !== 1'b1 || buf_filled !== 1'b0 || src_ready !== 1'b1) begin
            miss++;
            $display("FAIL swap: got sel=%b ack=%b filled=%b ready=%b want 1 1 0 1",
                     buf_sel, codec_empty_ack, buf_filled, src_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            vec++;
            if (buf_sel !== 1'b1 || codec_empty_ack !== 1'b0) begin
                miss++;
                $display("FAIL no_double_swap[%0d]: got sel=%b ack=%b want 1 0", k, buf_sel, codec_empty_ack);
            end
        end
        codec_empty = 1'b0;
        src_valid = 1'b1;
        src_data  = 8'hA5;
        step();
        vec++;
        if (ram_wren !== 1'b1 || ram_wr_addr !== 9'h000 || ram_wr_data !== 8'hA5) begin
            miss++;
            $display("FAIL first_write_half0: got wren=%b addr=%h data=%h want 1 000 a5",
                     ram_wren, ram_wr_addr, ram_wr_data);
        end
        src_valid = 1'b0;
        step();
        vec++;
        if (ram_wren !== 1'b0) begin
            miss++;
            $display("FAIL wren_one_cycle: got %b want 0", ram_wren);
        end
    endtask

    task automatic test_underrun();
        logic [DW-1:0] exp_data;
        for (int i = 1; i < 256; i++) begin
            src_valid = 1'b1;
            exp_data  = DW'(i) ^ 8'h3C;
            src_data  = exp_data;
            if (i == 100) codec_empty = 1'b1;
            step();
            vec++;
            if (ram_wren !== 1'b1 || ram_wr_addr !== 9'(i) || ram_wr_data !== exp_data
                || buf_sel !== 1'b1 || codec_empty_ack !== 1'b0 || buf_filled !== (i == 255)) begin
                miss++;
                $display("FAIL fill0[%0d]: got wren=%b addr=%h data=%h sel=%b ack=%b filled=%b want 1 %h %h 1 0 %b",
                         i, ram_wren, ram_wr_addr, ram_wr_data, buf_sel, codec_empty_ack, buf_filled,
                         9'(i), exp_data, (i == 255));
            end
`ifdef PINGPONG_UNDERRUN_CNT_EN
            if (i == 99 || i == 100) begin
                vec++;
                if (underrun_cnt !== ((i == 100) ? 16'd1 : 16'd0)) begin
                    miss++;
                    $display("FAIL underrun_cnt[%0d]: got %0d want %0d", i, underrun_cnt, (i == 100) ? 1 : 0);
                end
            end
`endif
        end
        src_valid = 1'b0;
        step();
        vec++;
        if (buf_sel !== 1'b0 || codec_empty_ack !== 1'b1 || buf_filled !== 1'b0) begin
            miss++;
            $display("FAIL swap_empty_early: got sel=%b ack=%b filled=%b want 0 1 0", buf_sel, codec_empty_ack, buf_filled);
        end
        step();
        vec++;
        if (codec_empty_ack !== 1'b0 || buf_sel !== 1'b0) begin
            miss++;
            $display("FAIL ack_drop: got ack=%b sel=%b want 0 0", codec_empty_ack, buf_sel);
        end
`ifdef PINGPONG_UNDERRUN_CNT_EN
        vec++;
        if (underrun_cnt !== 16'd1) begin
            miss++;
            $display("FAIL underrun_after_swap: got %0d want 1", underrun_cnt);
        end
`endif
        codec_empty = 1'b0;
    endtask

    task automatic test_backpressure();
        int idx;
        int nwr;
        logic [AW:0]   exp_addr;
        logic [DW-1:0] exp_data;
        idx = 0;
        nwr = 0;
        for (int k = 0; k < 511; k++) begin
            src_valid = ~k[0];
            exp_data  = DW'(idx) + 8'd7;
            exp_addr  = 9'h100 + 9'(idx);
            src_data  = exp_data;
            step();
            if (ram_wren === 1'b1) nwr++;
            vec++;
            if (src_valid) begin
                idx++;
                if (ram_wren !== 1'b1 || ram_wr_addr !== exp_addr || ram_wr_data !== exp_data
                    || buf_filled !== (idx == 256)) begin
                    miss++;
                    $display("FAIL bp_write[%0d]: got wren=%b addr=%h data=%h filled=%b want 1 %h %h %b",
                             k, ram_wren, ram_wr_addr, ram_wr_data, buf_filled, exp_addr, exp_data, (idx == 256));
                end
            end else if (ram_wren !== 1'b0) begin
                miss++;
                $display("FAIL bp_idle[%0d]: got wren=%b want 0", k, ram_wren);
            end
        end
        src_valid = 1'b0;
        vec++;
        if (nwr != 256 || src_ready !== 1'b0) begin
            miss++;
            $display("FAIL bp_total: got writes=%0d ready=%b want 256 0", nwr, src_ready);
        end
        codec_empty = 1'b1;
        step();
        vec++;
        if (buf_sel !== 1'b1 || codec_empty_ack !== 1'b1) begin
            miss++;
            $display("FAIL bp_swap: got sel=%b ack=%b want 1 1", buf_sel, codec_empty_ack);
        end
        codec_empty = 1'b0;
        step();
    endtask

    task automatic test_reset_midfill();
        for (int i = 0; i < 50; i++) begin
            src_valid = 1'b1;
            src_data  = DW'(i);
            step();
        end
        vec++;
        if (ram_wr_addr !== 9'h031 || buf_sel !== 1'b1) begin
            miss++;
            $display("FAIL midfill_addr: got addr=%h sel=%b want 031 1", ram_wr_addr, buf_sel);
        end
        src_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        vec++;
        if ({ram_wren, ram_wr_addr, ram_wr_data, buf_sel, buf_filled, codec_empty_ack} !== '0
            || src_ready !== 1'b1) begin
            miss++;
            $display("FAIL async_reset: got wren=%b addr=%h data=%h sel=%b filled=%b ack=%b ready=%b want 0s ready=1",
                     ram_wren, ram_wr_addr, ram_wr_data, buf_sel, buf_filled, codec_empty_ack, src_ready);
        end
        step();
        #2;
        rst = 1'b0;
        src_valid = 1'b1;
        src_data  = 8'h5A;
        step();
        vec++;
        if (ram_wren !== 1'b1 || ram_wr_addr !== 9'h100 || ram_wr_data !== 8'h5A || buf_sel !== 1'b0) begin
            miss++;
            $display("FAIL refill_restart: got wren=%b addr=%h data=%h sel=%b want 1 100 5a 0",
                     ram_wren, ram_wr_addr, ram_wr_data, buf_sel);
        end
        src_valid = 1'b0;
        step();
    endtask

    initial begin
        vec  = 0;
        miss = 0;
        test_reset();
        test_fill_half1();
        test_swap();
        test_underrun();
        test_backpressure();
        test_reset_midfill();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
